// File: rtl/digit_serdes.sv
// digit_serdes: digit-serial load/store engine; shifts in address/store data and
// shifts out load data DIGIT bits per beat against a 1-cycle-latency word memory.
module digit_serdes #(
  parameter int XLEN   = 32,
  parameter int DIGIT  = 1,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DIGIT-1:0]    din,
  output logic [DIGIT-1:0]    dout,
  output logic                dout_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  output logic [XLEN/8-1:0]   mem_we,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                misaligned
);
  localparam int N  = XLEN / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int BW = XLEN / 8;
  typedef enum logic [2:0] {IDLE, ADDR, RD, CAP, OUT, STIN, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic op_q, op_d, us_q, us_d, mis_q, mis_d;
  logic [1:0] size_q, size_d, off;
  logic [XLEN-1:0] sh, dmask, msb, ld;
  logic [BW-1:0] mask;
  logic last, bad, sign;
  assign off   = addr_q[1:0];
  assign last  = cnt_q == CW'(N - 1);
  assign dmask = size_q == 2'b00 ? XLEN'(8'hff) : size_q == 2'b01 ? XLEN'(16'hffff) : '1;
  assign mask  = size_q == 2'b00 ? BW'(1) : size_q == 2'b01 ? BW'(3) : '1;
  assign sh    = mem_rdata >> {off, 3'b000};
  // top bit of the kept field supplies the sign for narrow loads
  assign msb   = dmask & ~(dmask >> 1);
  assign sign  = |(sh & msb);
  assign ld    = (sh & dmask) | (~dmask & {XLEN{~us_q & sign}});
  assign bad   = size_q == 2'b11 || (size_q == 2'b01 && addr_d[0]) ||
                 (size_q == 2'b10 && addr_d[1:0] != 2'b00);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    op_d       = op_q;
    size_d     = size_q;
    us_d       = us_q;
    mis_d      = mis_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        size_d  = size;
        us_d    = is_unsigned;
        cnt_d   = '0;
        mis_d   = 1'b0;
        state_d = ADDR;
      end
      ADDR: begin
        addr_d = XLEN'({din, addr_q} >> DIGIT);
        cnt_d  = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          mis_d      = bad;
          mem_addr_d = bad ? mem_addr_q : addr_d[ADDR_W+1:2];
          state_d    = bad ? DONE : op_q ? STIN : RD;
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        data_d  = ld;
        state_d = OUT;
      end
      OUT: begin
        data_d  = data_q >> DIGIT;
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : OUT;
      end
      STIN: begin
        data_d  = XLEN'({din, data_q} >> DIGIT);
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? WR : STIN;
      end
      WR:   state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      op_q       <= 1'b0;
      size_q     <= 2'b00;
      us_q       <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      op_q       <= op_d;
      size_q     <= size_d;
      us_q       <= us_d;
      mis_q      <= mis_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign misaligned = done & mis_q;
  assign dout_valid = state_q == OUT;
  assign dout       = dout_valid ? data_q[DIGIT-1:0] : '0;
  assign mem_en     = state_q == RD || state_q == WR;
  assign mem_we     = state_q == WR ? mask << off : '0;
  assign mem_wdata  = state_q == WR ? (data_q & dmask) << {off, 3'b000} : '0;
  assign mem_addr   = mem_addr_q;
endmodule

// File: doc/digit_serdes.md
DIGIT_SERDES -- requirements
Module: digit_serdes

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data word width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter DIGIT, default 1, giving bits per serial beat; legal values 1, 2, 4 and 8; XLEN SHALL be a multiple of DIGIT.
REQ-003 The block SHALL have parameter ADDR_W, default 10, giving the memory word-address width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin transfer; accepted only in IDLE
- op  in  1  transfer type: 0 = load, 1 = store
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- is_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend
- din  in  DIGIT  serial address digits, then store-data digits, LSB first
- dout  out  DIGIT  serial load-data digit, LSB first
- dout_valid  out  1  dout holds a valid digit
- mem_addr  out  ADDR_W  word address, equal to address[ADDR_W+1:2]
- mem_en  out  1  memory enable
- mem_we  out  XLEN/8  byte write mask
- mem_wdata  out  XLEN  aligned store data
- mem_rdata  in  XLEN  memory read data; 1-cycle latency after mem_en
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  high together with done when the access was rejected

Function
REQ-006 Let N = XLEN/DIGIT; beat k carries bits [k*DIGIT +: DIGIT].
REQ-007 The FSM SHALL have these states: IDLE, ADDR, RD, CAP, OUT, STIN, WR, DONE.
REQ-008 In IDLE, start=1 SHALL latch op, size and is_unsigned, clear the beat counter, and move to ADDR; start outside IDLE SHALL be ignored.
REQ-009 ADDR SHALL sample din for N consecutive cycles into the address register, then perform the alignment check.
REQ-010 The alignment check SHALL fail if size=01 and addr[0]=1, if size=10 and addr[1:0]!=0, or if size=11; on failure the FSM SHALL go to DONE with misaligned=1 and no mem_en asserted.
REQ-011 After a passing check, a load SHALL go to RD and a store SHALL go to STIN.
REQ-012 RD SHALL last 1 cycle with mem_en=1, mem_we=0 and mem_addr driven.
REQ-013 CAP SHALL last 1 cycle and capture mem_rdata >> (8*addr[1:0]).
- Byte loads keep bits [7:0]; half loads keep bits [15:0].
- The upper bits SHALL be zero-filled (is_unsigned=1) or sign-filled (is_unsigned=0).
- Word loads keep all XLEN bits unchanged.
REQ-014 OUT SHALL last N cycles with dout_valid=1, dout = the current low digit, and a right shift by DIGIT each cycle; dout SHALL be 0 when dout_valid=0.
REQ-015 STIN SHALL sample din for N cycles into the store register; only the low byte or halfword is used for byte and half stores.
REQ-016 WR SHALL last 1 cycle with these outputs:
- mem_en=1
- mem_we = (size mask 0001, 0011 or 1111) << addr[1:0]
- mem_wdata = store data << (8*addr[1:0])
REQ-017 DONE SHALL last 1 cycle with done=1 and SHALL then return to IDLE; start sampled in DONE SHALL be ignored.
REQ-018 Latency from the start-accept edge to done: load 2N+3 cycles, store 2N+2 cycles, misaligned N+1 cycles.
REQ-019 The beat counter SHALL be ceil(log2(N)) bits wide and SHALL wrap to 0 at every state exit.
REQ-020 mem_addr SHALL hold its last value outside RD and WR; mem_en=0 and mem_we=0 outside RD and WR.

Reset
REQ-021 rst sampled high SHALL force IDLE and clear all of the following: address, data and beat registers, dout, dout_valid, mem_addr, mem_en, mem_we, mem_wdata, busy, done and misaligned.
REQ-022 rst SHALL take priority over start at the same edge.
REQ-023 A cycle in which rst is sampled high SHALL still drive its current-state outputs; a WR cycle coinciding with rst completes its write.
REQ-024 Reset mid-ADDR, mid-OUT or mid-STIN SHALL abandon the transfer with no done pulse.

Verification
REQ-025 The bench SHALL cover these directed scenarios (DIGIT=1, XLEN=32 unless stated):
- Word load, addr=0x00000010, mem[4]=0xDEADBEEF -> mem_addr=4 in RD; dout stream 0xDEADBEEF LSB first; done 67 cycles after start.
- Signed byte load, addr=0x13, mem[4]=0x80FF1234 -> output 0xFFFFFF80; same access with is_unsigned=1 -> 0x00000080.
- Half store, addr=0x06, data=0x0000ABCD -> mem_we=1100, mem_wdata=0xABCD0000, mem_addr=1, done at 66 cycles.
- Word access at addr=0x02 -> no mem_en at any point; done with misaligned=1 at 33 cycles; size=11 gives the same result.
- DIGIT=4 word load of 0x12345678 -> 8 beats: 8,7,6,5,4,3,2,1; done at 19 cycles.
- rst during OUT beat 5 -> next cycle busy=0, dout_valid=0, no done pulse; a start two cycles later is accepted normally.
